// File: rtl/segscan_decoder_if.sv
// Bus between the display-scanner side and the segscan decoder: the sampled
// scan lines, the frame-buffer read port and the status/error outputs.
interface segscan_decoder_if;
   logic [11:0] sel;
   logic [13:0] segm;
   logic [3:0]  rd_addr;
   logic [3:0]  rd_data;
   logic        clr_err;
   logic        in_sync;
   logic        frame_done;
   logic [7:0]  frame_cnt;
   logic        err_sel;
   logic        err_glyph;

   // Scanner / host side: drives the scan lines, read address and clear.
   modport master (
      output sel, segm, rd_addr, clr_err,
      input  rd_data, in_sync, frame_done, frame_cnt, err_sel, err_glyph
   );

   // Decoder side.
   modport slave (
      input  sel, segm, rd_addr, clr_err,
      output rd_data, in_sync, frame_done, frame_cnt, err_sel, err_glyph
   );
endinterface

// File: rtl/segscan_decoder.sv
// Receive-side decoder for the 12-digit multiplexed 14-segment display bus.
// Samples digit-select and segment lines, follows the scan sequence, decodes
// each glyph to a 4-bit character code and publishes every complete, clean
// frame into a 12-entry visible buffer with a registered read port.
module segscan_decoder (
   input  logic               clk,
   input  logic               rst,
   segscan_decoder_if.slave   bus
);

   localparam int unsigned NDIG     = 12;
   localparam logic [3:0]  LAST_POS = 4'd11;
   localparam logic [3:0]  CODE_BAD = 4'd15;

   // Glyph patterns, bit 13 = segment a.
   localparam logic [13:0] GLYPH_SPACE = 14'b00000000000000;
   localparam logic [13:0] GLYPH_0     = 14'b11111100001001;
   localparam logic [13:0] GLYPH_1     = 14'b01100000001000;
   localparam logic [13:0] GLYPH_8     = 14'b11111111000000;
   localparam logic [13:0] GLYPH_A     = 14'b11101111000000;
   localparam logic [13:0] GLYPH_B     = 14'b11110001010010;
   localparam logic [13:0] GLYPH_E     = 14'b10011110000000;
   localparam logic [13:0] GLYPH_F     = 14'b10001110000000;
   localparam logic [13:0] GLYPH_L     = 14'b00011100000000;
   localparam logic [13:0] GLYPH_S     = 14'b10110111000000;

   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Scan tracking
   state_t      state, state_nxt;
   logic [3:0]  pos, pos_nxt;
   logic [11:0] s_sel;
   logic [13:0] s_segm;
   logic [11:0] expect_sel;
   logic        sync_hit;

   // Decode / write control
   logic [3:0]  code;
   logic        glyph_bad;
   logic        wr_en;
   logic [3:0]  wr_pos;
   logic        sel_err;
   logic        clean, clean_nxt;
   logic        commit_req, commit_pend;

   // Buffers and registered outputs
   logic [3:0]  shadow  [NDIG];
   logic [3:0]  visible [NDIG];
   logic [3:0]  rd_data_q;
   logic        frame_done_q;
   logic [7:0]  frame_cnt_q;
   logic        err_sel_q;
   logic        err_glyph_q;
   logic        in_sync_c;

   assign expect_sel = 12'd1 << pos;
   assign sync_hit   = (s_sel == 12'h001);

   // Input stage: every decision below uses these registered copies.
   // NOTE: sequential state is assigned with non-blocking (<=) so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_sel  <= '0;
         s_segm <= '0;
      end else begin
         s_sel  <= bus.sel;
         s_segm <= bus.segm;
      end
   end

   // Exact-match glyph decode; anything unrecognised maps to code 15.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      code      = 4'd0;
      glyph_bad = 1'b0;
      case (s_segm)
         GLYPH_SPACE: code = 4'd0;
         GLYPH_0:     code = 4'd1;
         GLYPH_1:     code = 4'd2;
         GLYPH_8:     code = 4'd3;
         GLYPH_A:     code = 4'd4;
         GLYPH_B:     code = 4'd5;
         GLYPH_E:     code = 4'd6;
         GLYPH_F:     code = 4'd7;
         GLYPH_L:     code = 4'd8;
         GLYPH_S:     code = 4'd9;
         default: begin
            code      = CODE_BAD;
            glyph_bad = 1'b1;
         end
      endcase
   end

   // FSM state register: scan state and expected digit position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SYNC;
         pos   <= '0;
      end else begin
         state <= state_nxt;
         pos   <= pos_nxt;
      end
   end

   // FSM next state: follow the one-hot scan, drop to SYNC on any deviation.
   // A deviating sample that is exactly digit 0 restarts the frame at once.
   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      wr_en     = 1'b0;
      wr_pos    = '0;
      sel_err   = 1'b0;
      case (state)
         SYNC: begin
            if (sync_hit) begin
               wr_en     = 1'b1;
               wr_pos    = '0;
               pos_nxt   = 4'd1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (s_sel == expect_sel) begin
               wr_en   = 1'b1;
               wr_pos  = pos;
               pos_nxt = (pos == LAST_POS) ? 4'd0 : pos + 4'd1;
            end else begin
               sel_err = 1'b1;
               if (sync_hit) begin
                  wr_en     = 1'b1;
                  wr_pos    = '0;
                  pos_nxt   = 4'd1;
                  state_nxt = RUN;
               end else begin
                  pos_nxt   = '0;
                  state_nxt = SYNC;
               end
            end
         end
         default: begin
            pos_nxt   = '0;
            state_nxt = SYNC;
         end
      endcase
   end

   // FSM outputs.
   always_comb begin
      in_sync_c = (state == RUN);
   end

   // Frame-clean tracking: restarts at digit 0, cleared by any bad glyph.
   always_comb begin
      clean_nxt  = clean;
      commit_req = 1'b0;
      if (wr_en) begin
         clean_nxt  = ((wr_pos == 4'd0) ? 1'b1 : clean) & ~glyph_bad;
         commit_req = (wr_pos == LAST_POS) & clean & ~glyph_bad;
      end
   end

   // Shadow write and clean flag; commit request is held for one cycle so
   // the last digit lands in the shadow before it is copied out.
   // NOTE: both buffers are reset explicitly because a reset must read back
   // as spaces; a plain RAM macro could not be used here for that reason.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NDIG; i++) shadow[i] <= '0;
         clean       <= 1'b0;
         commit_pend <= 1'b0;
      end else begin
         if (wr_en) shadow[wr_pos] <= code;
         clean       <= clean_nxt;
         commit_pend <= commit_req;
      end
   end

   // Commit: copy shadow to visible, count the frame and pulse frame_done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NDIG; i++) visible[i] <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         frame_done_q <= commit_pend;
         if (commit_pend) begin
            for (int i = 0; i < NDIG; i++) visible[i] <= shadow[i];
            frame_cnt_q <= frame_cnt_q + 8'd1;
         end
      end
   end

   // Registered read port; out-of-range addresses read as space.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (bus.rd_addr < 4'd12) begin
         rd_data_q <= visible[bus.rd_addr];
      end else begin
         rd_data_q <= '0;
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sel_q   <= 1'b0;
         err_glyph_q <= 1'b0;
      end else begin
         err_sel_q   <= (err_sel_q & ~bus.clr_err) | sel_err;
         err_glyph_q <= (err_glyph_q & ~bus.clr_err) | (wr_en & glyph_bad);
      end
   end

   assign bus.rd_data    = rd_data_q;
   assign bus.in_sync    = in_sync_c;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_cnt  = frame_cnt_q;
   assign bus.err_sel    = err_sel_q;
   assign bus.err_glyph  = err_glyph_q;

endmodule

// File: tb/tb_segscan_decoder.sv
// Self-checking bench for segscan_decoder: directed scan sequences, with a
// scoreboard of expected commits and reads checked by a separate monitor.
module tb_segscan_decoder;

   logic clk = 1'b0;
   logic rst = 1'b0;

   segscan_decoder_if bus ();

   segscan_decoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] cnt;
      logic [31:0] due;
   } frame_exp_t;

   frame_exp_t  frame_q [$];
   int unsigned rd_q [$];
   frame_exp_t  mon_e;
   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned cyc    = 0;
   int unsigned model_cnt = 0;
   logic        rd_req  = 1'b0;
   logic        rd_fire = 1'b0;

   // "EFABLESS 180" and a second distinct content set
   int nominal [12] = '{6, 7, 4, 5, 8, 6, 9, 9, 0, 2, 3, 1};
   int alt     [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
   int zeros   [12] = '{default: 0};

   function automatic logic [13:0] seg_of(input int c);
      case (c)
         0: return 14'b00000000000000;
         1: return 14'b11111100001001;
         2: return 14'b01100000001000;
         3: return 14'b11111111000000;
         4: return 14'b11101111000000;
         5: return 14'b11110001010010;
         6: return 14'b10011110000000;
         7: return 14'b10001110000000;
         8: return 14'b00011100000000;
         9: return 14'b10110111000000;
         default: return 14'h3FFF;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: cycle counter and read-issue tracking at the active edge,
   // comparisons on the falling edge.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_fire <= rd_req;
   end

   always @(negedge clk) begin
      if (bus.frame_done === 1'b1) begin
         if (frame_q.size() == 0) begin
            check("frame_done_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = frame_q.pop_front();
            check("frame_cnt", 32'(bus.frame_cnt), mon_e.cnt);
            check("frame_done_cycle", cyc, mon_e.due);
         end
      end
      if (rd_fire) begin
         if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
         else check("rd_data", 32'(bus.rd_data), rd_q.pop_front());
      end
   end

   // Stimulus helpers: each drive() presents values and returns 1ns after
   // the edge that registers them.
   task automatic drive(input logic [11:0] s, input logic [13:0] g);
      bus.sel  = s;
      bus.segm = g;
      @(posedge clk);
      #1;
   endtask

   task automatic digit(input int p, input int c);
      drive(12'd1 << p, seg_of(c));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(12'h000, 14'h0000);
   endtask

   // Called right after the last digit is registered: commit lands 2 edges later.
   task automatic expect_commit();
      frame_exp_t e;
      model_cnt = (model_cnt + 1) % 256;
      e.cnt = model_cnt;
      e.due = cyc + 2;
      frame_q.push_back(e);
   endtask

   task automatic scan_frame(input int codes [12], input int bad_pos, input bit commit);
      for (int p = 0; p < 12; p++) begin
         if (p == bad_pos) drive(12'd1 << p, 14'h3FFF);
         else digit(p, codes[p]);
      end
      if (commit) expect_commit();
   endtask

   task automatic rd(input int a, input int exp);
      bus.rd_addr = a[3:0];
      rd_req = 1'b1;
      rd_q.push_back(exp);
      @(posedge clk);
      #1;
      rd_req = 1'b0;
   endtask

   task automatic read_all(input int codes [12]);
      for (int i = 0; i < 12; i++) rd(i, codes[i]);
      rd(12, 0);
      rd(15, 0);
   endtask

   task automatic clr_pulse();
      bus.clr_err = 1'b1;
      @(posedge clk);
      #1;
      bus.clr_err = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.sel = '0; bus.segm = '0; bus.rd_addr = '0; bus.clr_err = 1'b0;

      // Reset values
      #1 rst = 1'b1;
      #2;
      check("rst_in_sync",    32'(bus.in_sync),    32'd0);
      check("rst_frame_done", 32'(bus.frame_done), 32'd0);
      check("rst_frame_cnt",  32'(bus.frame_cnt),  32'd0);
      check("rst_err_sel",    32'(bus.err_sel),    32'd0);
      check("rst_err_glyph",  32'(bus.err_glyph),  32'd0);
      check("rst_rd_data",    32'(bus.rd_data),    32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      idle(3);
      check("sync_ignores_zero", 32'(bus.err_sel), 32'd0);

      // Nominal: three frames, then read back during a fourth
      scan_frame(nominal, -1, 1'b1);
      check("nominal_in_sync", 32'(bus.in_sync), 32'd1);
      scan_frame(nominal, -1, 1'b1);
      scan_frame(nominal, -1, 1'b1);
      check("nominal_err_sel",   32'(bus.err_sel),   32'd0);
      check("nominal_err_glyph", 32'(bus.err_glyph), 32'd0);
      fork
         scan_frame(nominal, -1, 1'b1);
         begin
            repeat (3) begin @(posedge clk); #1; end
            read_all(nominal);
         end
      join
      idle(3);
      check("stop_err_sel", 32'(bus.err_sel), 32'd1);
      check("stop_in_sync", 32'(bus.in_sync), 32'd0);
      clr_pulse();
      check("clr_err_sel", 32'(bus.err_sel), 32'd0);

      // Mid-frame start: positions 5..11 ignored until digit 0
      for (int p = 5; p < 12; p++) digit(p, 3);
      check("midstart_in_sync", 32'(bus.in_sync), 32'd0);
      check("midstart_err_sel", 32'(bus.err_sel), 32'd0);
      scan_frame(alt, -1, 1'b1);
      check("midstart_clean_err_sel", 32'(bus.err_sel), 32'd0);
      idle(3);
      clr_pulse();
      read_all(alt);

      // Skipped digit: 7 followed by 9
      for (int p = 0; p < 8; p++) digit(p, 3);
      digit(9, 3);
      idle(2);
      check("skip_err_sel", 32'(bus.err_sel), 32'd1);
      check("skip_in_sync", 32'(bus.in_sync), 32'd0);
      read_all(alt);
      clr_pulse();
      scan_frame(nominal, -1, 1'b1);
      check("resync_err_sel", 32'(bus.err_sel), 32'd0);
      idle(3);
      clr_pulse();

      // Bad glyph at position 4: no commit, next clean frame commits
      scan_frame(alt, 4, 1'b0);
      check("badglyph_err_glyph", 32'(bus.err_glyph), 32'd1);
      check("badglyph_in_sync",   32'(bus.in_sync),   32'd1);
      scan_frame(alt, -1, 1'b1);
      check("badglyph_err_sel", 32'(bus.err_sel), 32'd0);
      idle(3);
      clr_pulse();
      check("clr_err_glyph", 32'(bus.err_glyph), 32'd0);
      read_all(alt);

      // Two-hot select
      for (int p = 0; p < 3; p++) digit(p, nominal[p]);
      drive(12'h003, seg_of(1));
      drive(12'h000, 14'h0000);
      check("twohot_err_sel", 32'(bus.err_sel), 32'd1);
      check("twohot_in_sync", 32'(bus.in_sync), 32'd0);
      clr_pulse();
      check("twohot_clr", 32'(bus.err_sel), 32'd0);
      digit(0, 1);
      digit(1, 2);
      drive(12'h003, seg_of(1));
      bus.clr_err = 1'b1;
      drive(12'h000, 14'h0000);
      bus.clr_err = 1'b0;
      check("clr_vs_new_err", 32'(bus.err_sel), 32'd1);
      clr_pulse();

      // Mismatching digit 0 restarts the frame immediately
      for (int p = 0; p < 5; p++) digit(p, alt[p]);
      digit(0, nominal[0]);
      digit(1, nominal[1]);
      check("restart_err_sel", 32'(bus.err_sel), 32'd1);
      check("restart_in_sync", 32'(bus.in_sync), 32'd1);
      for (int p = 2; p < 12; p++) digit(p, nominal[p]);
      expect_commit();
      idle(3);
      read_all(nominal);

      // Async reset mid-frame at position 6
      bus.rd_addr = 4'd0;
      for (int p = 0; p < 7; p++) digit(p, nominal[p]);
      #2 rst = 1'b1;
      #1;
      check("arst_in_sync",    32'(bus.in_sync),    32'd0);
      check("arst_frame_cnt",  32'(bus.frame_cnt),  32'd0);
      check("arst_frame_done", 32'(bus.frame_done), 32'd0);
      check("arst_err_sel",    32'(bus.err_sel),    32'd0);
      check("arst_rd_data",    32'(bus.rd_data),    32'd0);
      model_cnt = 0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      idle(2);
      check("arst_resume_in_sync", 32'(bus.in_sync), 32'd0);
      read_all(zeros);

      // frame_cnt wrap after 256 back-to-back commits
      for (int f = 0; f < 256; f++) scan_frame(nominal, -1, 1'b1);
      idle(3);
      check("wrap_frame_cnt", 32'(bus.frame_cnt), 32'd0);

      idle(3);
      check("frame_q_drained", 32'(frame_q.size()), 32'd0);
      check("rd_q_drained",    32'(rd_q.size()),    32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/segscan_decoder.md
# segscan_decoder

Receive-side decoder for the 12-digit multiplexed 14-segment display bus. It samples the one-hot digit-select and segment lines driven by the display scanner and tracks the scan sequence. It decodes each 14-bit glyph back to a 4-bit character code and publishes each complete, cleanly scanned frame into a readable 12-entry buffer. It sits on the same clock as the scanner and serves as a loopback checker and as the input stage for display mirroring.

## Interface
- No parameters. Digit count is fixed at 12, segment width at 14 and the glyph set at 10.
- clk  in  1  rising-edge clock, shared with the display scanner
- rst  in  1  asynchronous, active-high reset
- sel  in  12  digit select, one-hot; bit i = digit position i (bit 0 = first digit)
- segm  in  14  segment pattern for the selected digit, bit 13 = segment a
- rd_addr  in  4  frame-buffer read address, 0..11
- rd_data  out  4  character code at rd_addr, registered
- clr_err  in  1  clears err_sel and err_glyph
- in_sync  out  1  high while state = RUN
- frame_done  out  1  one-cycle pulse when a new frame is committed
- frame_cnt  out  8  committed-frame counter, wraps 255 -> 0
- err_sel  out  1  sticky: sequence or one-hot violation seen
- err_glyph  out  1  sticky: unrecognised segment pattern seen

## Operation
- Input stage: sel and segm are registered every cycle into s_sel and s_segm. All decisions use the registered copies.
- Glyph decode (combinational on s_segm, exact match; code: pattern):
  - 0 space: 00000000000000
  - 1 '0': 11111100001001
  - 2 '1': 01100000001000
  - 3 '8': 11111111000000
  - 4 'A': 11101111000000
  - 5 'B': 11110001010010
  - 6 'E': 10011110000000
  - 7 'F': 10001110000000
  - 8 'L': 00011100000000
  - 9 'S': 10110111000000
  - Any other pattern: code 15, and err_glyph is set.
- State SYNC:
  - The decoder waits for s_sel == 12'h001.
  - On that value it writes the decoded code to shadow[0], sets pos = 1 and enters RUN.
  - All other values are ignored: no write, no error.
- State RUN: each cycle s_sel must equal 1 << pos.
  - Match: write shadow[pos]. Track a frame-clean flag; it is cleared on any err_glyph event within the frame.
  - If pos == 11: pos wraps to 0, the shadow is committed if the frame was clean, and the decoder stays in RUN.
  - Mismatch (including zero, multiple bits, or a skipped or repeated digit): set err_sel, discard the shadow contents, and return to SYNC. The mismatching sample is re-evaluated as a SYNC sample in the same cycle, so 12'h001 immediately restarts the frame at position 0.
- Commit:
  - Visible buffer[0..11] <= shadow[0..11].
  - frame_cnt increments.
  - frame_done pulses.
- A frame that contains a code-15 glyph is not committed. err_glyph is still set and the scan stays in RUN.
- Read port: rd_data <= visible[rd_addr] on every clock. An rd_addr value of 12..15 returns 0.
- Sticky flags: clr_err clears both flags. If a new error occurs in the same cycle as clr_err, the error wins and the flag stays set.

## Timing
- Reset (asynchronous) values:
  - State SYNC, pos 0, in_sync 0.
  - s_sel and s_segm 0.
  - Shadow and visible buffers all 0 (space).
  - rd_data 0, frame_done 0, frame_cnt 0.
  - err_sel 0, err_glyph 0.
- A reset asserted mid-frame discards the partial frame. Scanning resumes from SYNC after release.
- Latency, where sel/segm are presented before edge k:
  - Registered at edge k.
  - Shadow write and state update at edge k+1.
  - For position 11 of a clean frame: visible update and frame_done = 1 at edge k+2, low again after edge k+3.
- Back-to-back frames (one digit per clock) commit every 12 cycles. frame_done is high for 1 of every 12 cycles.
- Read at the commit edge: rd_data returns the pre-commit contents. New contents are visible on the read issued one cycle later.
- in_sync rises at edge k+1 after the first s_sel == 12'h001 is registered.

## Test plan
- Nominal scan: the scanner sequence "EFABLESS 180" (E,F,A,B,L,E,S,S,space,1,8,0) runs for 3 frames.
  - First frame_done comes 2 cycles after the last digit is registered.
  - frame_cnt = 3.
  - Reading addr 0..11 gives 6,7,4,5,8,6,9,9,0,2,3,1.
  - err flags stay 0.
- Mid-frame start: sel begins at position 5. No writes occur until sel = 12'h001. The first commit is a full frame, and err_sel stays 0.
- Skipped digit: position 7 is followed directly by position 9.
  - err_sel = 1, in_sync drops, and no frame_done for that frame.
  - The visible buffer keeps the previous frame.
  - Resync on the next 12'h001, then a clean commit.
- Bad glyph: segm = 14'h3FFF at position 4. err_glyph = 1, the frame is not committed, and the next clean frame commits normally.
- Two-hot sel (12'h003): err_sel = 1 and the decoder returns to SYNC. Assert clr_err in the same cycle as a fresh violation; err_sel must remain 1.
- Async reset asserted at position 6 mid-frame: all outputs go to reset values immediately and the buffer reads 0. frame_cnt wraps 255 -> 0 after 256 commits (separate run).
